// File: rtl/noc_host.sv
// noc_host: host-side NoC endpoint. Turns read/write requests into command packets on a
// byte-serial link and decodes response and message packets coming back.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake; req_write, req_alen, req_dlen, req_dest,
//                              req_addr describe the transaction
//   wr_push, wr_data, wr_count 128-byte write-payload FIFO fill port and occupancy
//   noc_to_dev_ctl/data        outbound byte stream (ctl=1 marks a command byte)
//   noc_from_dev_ctl/data      inbound byte stream
//   rsp_valid, rsp_write, rsp_rc, rsp_len, rsp_timeout   transaction completion
//   rdata_valid, rdata         read payload bytes
//   msg_valid, msg_addr, msg_data                        received message packets
module noc_host #(
    parameter logic [7:0]  SRC_ID  = 8'h01,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_alen,
    input  logic [2:0]  req_dlen,
    input  logic [7:0]  req_dest,
    input  logic [63:0] req_addr,
    input  logic        wr_push,
    input  logic [7:0]  wr_data,
    output logic [7:0]  wr_count,
    output logic        noc_to_dev_ctl,
    output logic [7:0]  noc_to_dev_data,
    input  logic        noc_from_dev_ctl,
    input  logic [7:0]  noc_from_dev_data,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [1:0]  rsp_rc,
    output logic [7:0]  rsp_len,
    output logic        rsp_timeout,
    output logic        rdata_valid,
    output logic [7:0]  rdata,
    output logic        msg_valid,
    output logic [7:0]  msg_addr,
    output logic [7:0]  msg_data
);

    typedef enum logic [2:0] {TxIdle, TxCmd, TxDest, TxSrc, TxAddr, TxData, TxWait} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxDest, RxSrc, RxHdr, RxPay} rx_state_e;

    localparam logic [2:0] OpRead  = 3'b001;
    localparam logic [2:0] OpWrite = 3'b010;
    localparam logic [2:0] OpRdRsp = 3'b011;
    localparam logic [2:0] OpWrRsp = 3'b100;
    localparam logic [2:0] OpMsg   = 3'b101;
    localparam logic [1:0] RcPart  = 2'b10;

    // Write-payload FIFO
    logic [7:0] mem [128];
    logic [6:0] wr_ptr_q, rd_ptr_q;
    logic [7:0] wr_count_q;

    // Transmit side; tx_state_q names the byte currently on the outbound wires
    tx_state_e  tx_state_q;
    logic       wr_q;
    logic [1:0] alen_q;
    logic [2:0] dlen_q;
    logic [7:0] dest_q;
    logic [63:0] addr_q;
    logic [7:0] cnt_q;
    logic [31:0] timer_q;
    logic [7:0] acc_q;

    // Receive side
    rx_state_e  rx_state_q;
    logic [2:0] rx_code_q;
    logic [1:0] rx_rc_q;
    logic       rx_keep_q;
    logic [7:0] rx_left_q;
    logic [7:0] msg_hold_q;
    logic       fin_pend_q;

    logic [7:0] naddr, ndata, req_bytes, done_len, head;
    logic       waiting, hs, pop, push_ok, rx_cmd_ok, dest_keep, rsp_byte, done, timeout_hit;

    assign wr_count = wr_count_q;
    assign head     = mem[rd_ptr_q];

    always_comb begin
        naddr       = 8'd1 << alen_q;
        ndata       = 8'd1 << dlen_q;
        req_bytes   = 8'd1 << req_dlen;
        waiting     = (tx_state_q == TxWait);
        req_ready   = !rst && (tx_state_q == TxIdle) && (!req_write || (wr_count_q >= req_bytes));
        hs          = req_valid && req_ready;
        pop         = ((tx_state_q == TxAddr) && (cnt_q == naddr) && wr_q) ||
                      ((tx_state_q == TxData) && (cnt_q != ndata));
        push_ok     = wr_push && (wr_count_q != 8'd128);
        rx_cmd_ok   = noc_from_dev_ctl &&
                      (noc_from_dev_data[2:0] inside {OpRdRsp, OpWrRsp, OpMsg});
        // Responses are only taken while a transaction waits; messages always.
        dest_keep   = (noc_from_dev_data == SRC_ID) && ((rx_code_q == OpMsg) || waiting);
        rsp_byte    = ((rx_state_q == RxDest) && dest_keep && (rx_code_q != OpMsg)) ||
                      ((rx_state_q inside {RxSrc, RxHdr, RxPay}) && rx_keep_q &&
                       (rx_code_q != OpMsg));
        timeout_hit = (timer_q == 32'(TIMEOUT - 1));

        done     = 1'b0;
        done_len = acc_q;
        if (fin_pend_q) begin
            done = 1'b1;
        end else if ((rx_state_q == RxHdr) && rx_keep_q && (rx_code_q != OpMsg)) begin
            if (rx_code_q == OpWrRsp) begin
                done     = 1'b1;
                done_len = noc_from_dev_data;
            end else if ((noc_from_dev_data == 8'd0) && (rx_rc_q != RcPart)) begin
                done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            wr_count_q      <= '0;
            tx_state_q      <= TxIdle;
            wr_q            <= 1'b0;
            alen_q          <= '0;
            dlen_q          <= '0;
            dest_q          <= '0;
            addr_q          <= '0;
            cnt_q           <= '0;
            timer_q         <= '0;
            acc_q           <= '0;
            rx_state_q      <= RxIdle;
            rx_code_q       <= '0;
            rx_rc_q         <= '0;
            rx_keep_q       <= 1'b0;
            rx_left_q       <= '0;
            msg_hold_q      <= '0;
            fin_pend_q      <= 1'b0;
            noc_to_dev_ctl  <= 1'b1;
            noc_to_dev_data <= 8'h00;
            rsp_valid       <= 1'b0;
            rsp_write       <= 1'b0;
            rsp_rc          <= '0;
            rsp_len         <= '0;
            rsp_timeout     <= 1'b0;
            rdata_valid     <= 1'b0;
            rdata           <= '0;
            msg_valid       <= 1'b0;
            msg_addr        <= '0;
            msg_data        <= '0;
        end else begin
            rsp_valid   <= 1'b0;
            rdata_valid <= 1'b0;
            msg_valid   <= 1'b0;
            fin_pend_q  <= 1'b0;

            if (push_ok) wr_ptr_q <= wr_ptr_q + 7'd1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 7'd1;
            wr_count_q <= wr_count_q + {7'd0, push_ok} - {7'd0, pop};

            case (tx_state_q)
                TxIdle: begin
                    if (hs) begin
                        wr_q            <= req_write;
                        alen_q          <= req_alen;
                        dlen_q          <= req_dlen;
                        dest_q          <= req_dest;
                        addr_q          <= req_addr;
                        acc_q           <= 8'd0;
                        noc_to_dev_ctl  <= 1'b1;
                        noc_to_dev_data <= {req_alen, req_dlen, req_write ? OpWrite : OpRead};
                        tx_state_q      <= TxCmd;
                    end
                end
                TxCmd: begin
                    noc_to_dev_ctl  <= 1'b0;
                    noc_to_dev_data <= dest_q;
                    tx_state_q      <= TxDest;
                end
                TxDest: begin
                    noc_to_dev_data <= SRC_ID;
                    tx_state_q      <= TxSrc;
                end
                TxSrc: begin
                    noc_to_dev_data <= addr_q[7:0];
                    addr_q          <= addr_q >> 8;
                    cnt_q           <= 8'd1;
                    tx_state_q      <= TxAddr;
                end
                TxAddr: begin
                    if (cnt_q != naddr) begin
                        noc_to_dev_data <= addr_q[7:0];
                        addr_q          <= addr_q >> 8;
                        cnt_q           <= cnt_q + 8'd1;
                    end else if (wr_q) begin
                        noc_to_dev_data <= head;
                        cnt_q           <= 8'd1;
                        tx_state_q      <= TxData;
                    end else begin
                        noc_to_dev_ctl  <= 1'b1;
                        noc_to_dev_data <= 8'h00;
                        timer_q         <= '0;
                        tx_state_q      <= TxWait;
                    end
                end
                TxData: begin
                    if (cnt_q != ndata) begin
                        noc_to_dev_data <= head;
                        cnt_q           <= cnt_q + 8'd1;
                    end else begin
                        noc_to_dev_ctl  <= 1'b1;
                        noc_to_dev_data <= 8'h00;
                        timer_q         <= '0;
                        tx_state_q      <= TxWait;
                    end
                end
                TxWait: begin
                    if (done) begin
                        rsp_valid   <= 1'b1;
                        rsp_write   <= wr_q;
                        rsp_rc      <= rx_rc_q;
                        rsp_len     <= done_len;
                        rsp_timeout <= 1'b0;
                        tx_state_q  <= TxIdle;
                    end else if (rsp_byte) begin
                        timer_q <= '0;
                    end else if (timeout_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_write   <= wr_q;
                        rsp_rc      <= 2'b11;
                        rsp_len     <= acc_q;
                        rsp_timeout <= 1'b1;
                        tx_state_q  <= TxIdle;
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase

            case (rx_state_q)
                RxIdle: begin
                    if (rx_cmd_ok) begin
                        rx_code_q  <= noc_from_dev_data[2:0];
                        rx_rc_q    <= noc_from_dev_data[7:6];
                        rx_state_q <= RxDest;
                    end
                end
                RxDest: begin
                    rx_keep_q  <= dest_keep;
                    rx_state_q <= RxSrc;
                end
                RxSrc: rx_state_q <= RxHdr;
                RxHdr: begin
                    // Dropped packets end here; their trailing ctl=0 bytes are ignored in idle.
                    rx_state_q <= RxIdle;
                    if (rx_keep_q) begin
                        if (rx_code_q == OpMsg) begin
                            msg_hold_q <= noc_from_dev_data;
                            rx_state_q <= RxPay;
                        end else if (rx_code_q == OpRdRsp) begin
                            acc_q <= acc_q + noc_from_dev_data;
                            if (noc_from_dev_data != 8'd0) begin
                                rx_left_q  <= noc_from_dev_data;
                                rx_state_q <= RxPay;
                            end
                        end
                    end
                end
                RxPay: begin
                    if (rx_code_q == OpMsg) begin
                        msg_valid  <= 1'b1;
                        msg_addr   <= msg_hold_q;
                        msg_data   <= noc_from_dev_data;
                        rx_state_q <= RxIdle;
                    end else begin
                        rdata_valid <= 1'b1;
                        rdata       <= noc_from_dev_data;
                        rx_left_q   <= rx_left_q - 8'd1;
                        if (rx_left_q == 8'd1) begin
                            rx_state_q <= RxIdle;
                            // Completion is reported the cycle after the last rdata pulse.
                            if (rx_rc_q != RcPart) fin_pend_q <= 1'b1;
                        end
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

endmodule
